// File: rtl/lockstep_stim_pkg.sv
// Purpose: shared types and constants for the lockstep stimulus generator.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package lockstep_stim_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Injection counter width and the value it saturates at.
  localparam int                   INJ_CNT_W   = 8;
  localparam logic [INJ_CNT_W-1:0] INJ_CNT_MAX = 8'd255;

endpackage

// File: rtl/stim_delay_line.sv
// Purpose: WIDTH x LAG register chain with synchronous clear, delays d_i by LAG edges.
// Latency: LAG clock edges from d_i to q_o.
// Backpressure: none; shifts on every edge.
// Ports: clk (clock), clr (synchronous clear of every stage), d_i (input word),
//        q_o (oldest stage).
module stim_delay_line #(
  parameter int WIDTH = 4,
  parameter int LAG   = 1
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [LAG-1:0][WIDTH-1:0] stage_q;
  logic [LAG-1:0][WIDTH-1:0] stage_d;

  always_comb begin
    stage_d    = stage_q;
    stage_d[0] = d_i;
    for (int i = 1; i < LAG; i++) begin
      stage_d[i] = stage_q[i-1];
    end
    if (clr) begin
      stage_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    stage_q <= stage_d;
  end

  assign q_o = stage_q[LAG-1];

endmodule

// File: rtl/lockstep_stim_gen.sv
// Purpose: two lockstep WIDTH-bit counter streams with single-cycle XOR injection on b_o.
// Latency: start to first increment 2 edges; start to done NUM_CYCLES+1 edges (+LAG with delay).
// Backpressure: none; start in RUN is ignored, inject outside RUN is ignored.
// Ports: clk, rst (sync, active high), start, inject -> a_o, b_o, busy, done, inj_cnt.
// Optional: define STIM_GEN_LAG_EN to delay b_o by LAG edges through stim_delay_line;
//           busy then stays high until the last b_o value has emerged.
module lockstep_stim_gen #(
  parameter int          WIDTH      = 4,
  parameter int          NUM_CYCLES = 10,
  parameter int unsigned INJ_MASK   = 1,
  parameter int          LAG        = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             inject,
  output logic [WIDTH-1:0] a_o,
  output logic [WIDTH-1:0] b_o,
  output logic             busy,
  output logic             done,
  output logic [7:0]       inj_cnt
);

  import lockstep_stim_pkg::*;

`ifdef STIM_GEN_LAG_EN
  localparam int DRAIN_EDGES = LAG;
`else
  localparam int DRAIN_EDGES = 0 * LAG;
`endif

  localparam logic [WIDTH-1:0] MASK      = WIDTH'(INJ_MASK);
  localparam logic [15:0]      LAST_CYC  = 16'(NUM_CYCLES);
  localparam logic [15:0]      FINAL_INC = 16'(NUM_CYCLES - 1);
  localparam logic [3:0]       DRAIN_END = 4'(DRAIN_EDGES - 1);

  state_e                 state_q, state_d;
  logic [WIDTH-1:0]       a_q, a_d;
  logic [WIDTH-1:0]       b_q, b_d;
  logic [15:0]            cyc_q, cyc_d;
  logic [INJ_CNT_W-1:0]   inj_q, inj_d;
  logic [3:0]             drain_q, drain_d;
  logic [WIDTH-1:0]       a_inc;
  logic                   run_start;

  assign a_inc = a_q + 1'b1;

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    cyc_d     = cyc_q;
    inj_d     = inj_q;
    drain_d   = drain_q;
    run_start = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d   = RUN;
          a_d       = '0;
          b_d       = '0;
          cyc_d     = '0;
          inj_d     = '0;
          drain_d   = '0;
          run_start = 1'b1;
        end
      end
      RUN: begin
        if (cyc_q != LAST_CYC) begin
          a_d   = a_inc;
          b_d   = a_inc ^ (inject ? MASK : '0);
          cyc_d = cyc_q + 16'd1;
          if (inject && (inj_q != INJ_CNT_MAX)) begin
            inj_d = inj_q + 1'b1;
          end
          if ((cyc_q == FINAL_INC) && (DRAIN_EDGES == 0)) begin
            state_d = DONE;
          end
        end else begin
          // All increments issued; hold counters while the delayed b_o drains out.
          drain_d = drain_q + 4'd1;
          if (drain_q == DRAIN_END) begin
            state_d = DONE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      cyc_q   <= '0;
      inj_q   <= '0;
      drain_q <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cyc_q   <= cyc_d;
      inj_q   <= inj_d;
      drain_q <= drain_d;
    end
  end

`ifdef STIM_GEN_LAG_EN
  stim_delay_line #(
    .WIDTH (WIDTH),
    .LAG   (LAG)
  ) u_delay (
    .clk (clk),
    .clr (rst | run_start),
    .d_i (b_q),
    .q_o (b_o)
  );
`else
  assign b_o = b_q;
`endif

  assign a_o     = a_q;
  assign busy    = (state_q == RUN);
  assign done    = (state_q == DONE);
  assign inj_cnt = inj_q;

endmodule

// File: tb/tb_lockstep_stim_gen.sv
module tb_lockstep_stim_gen;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst0 = 1'b1, start0 = 1'b0, inj0 = 1'b0;
  logic [3:0] a0, b0;
  logic       busy0, done0;
  logic [7:0] cnt0;

  logic       rst1 = 1'b1, start1 = 1'b0, inj1 = 1'b0;
  logic [3:0] a1, b1;
  logic       busy1, done1;
  logic [7:0] cnt1;

  lockstep_stim_gen #(.WIDTH(4), .NUM_CYCLES(10), .INJ_MASK(1), .LAG(2)) dut0 (
    .clk(clk), .rst(rst0), .start(start0), .inject(inj0),
    .a_o(a0), .b_o(b0), .busy(busy0), .done(done0), .inj_cnt(cnt0)
  );

  lockstep_stim_gen #(.WIDTH(4), .NUM_CYCLES(20), .INJ_MASK(1), .LAG(2)) dut1 (
    .clk(clk), .rst(rst1), .start(start1), .inject(inj1),
    .a_o(a1), .b_o(b1), .busy(busy1), .done(done1), .inj_cnt(cnt1)
  );

  typedef struct {
    logic       rst;
    logic       start;
    logic       inject;
    logic [3:0] a;
    logic [3:0] b;
    logic       busy;
    logic       done;
    logic [7:0] cnt;
  } vec_t;

  vec_t tbl[$];
  vec_t q0[$];
  vec_t q1[$];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic add(input int r, input int s, input int i, input int a, input int b,
                     input int bsy, input int dn, input int c);
    vec_t v;
    v.rst = r[0]; v.start = s[0]; v.inject = i[0];
    v.a = a[3:0]; v.b = b[3:0]; v.busy = bsy[0]; v.done = dn[0]; v.cnt = c[7:0];
    tbl.push_back(v);
  endtask

  task automatic step0(input vec_t v, input int idx);
    vec_t e;
    rst0 = v.rst; start0 = v.start; inj0 = v.inject;
    q0.push_back(v);
    @(posedge clk); #1;
    e = q0.pop_front();
    chk($sformatf("v%0d.a", idx), int'(a0), int'(e.a));
    chk($sformatf("v%0d.b", idx), int'(b0), int'(e.b));
    chk($sformatf("v%0d.busy", idx), int'(busy0), int'(e.busy));
    chk($sformatf("v%0d.done", idx), int'(done0), int'(e.done));
    chk($sformatf("v%0d.inj_cnt", idx), int'(cnt0), int'(e.cnt));
  endtask

  task automatic step1(input vec_t v, input int idx);
    vec_t e;
    rst1 = v.rst; start1 = v.start; inj1 = v.inject;
    q1.push_back(v);
    @(posedge clk); #1;
    e = q1.pop_front();
    chk($sformatf("w%0d.a", idx), int'(a1), int'(e.a));
    chk($sformatf("w%0d.b", idx), int'(b1), int'(e.b));
    chk($sformatf("w%0d.busy", idx), int'(busy1), int'(e.busy));
    chk($sformatf("w%0d.done", idx), int'(done1), int'(e.done));
    chk($sformatf("w%0d.inj_cnt", idx), int'(cnt1), int'(e.cnt));
  endtask

  initial begin
    // Fields: rst start inject | a b busy done inj_cnt (expected after the edge)
    add(1,0,0, 0,0,0,0,0);          // reset
    add(0,0,1, 0,0,0,0,0);          // inject in IDLE ignored
    add(0,1,0, 0,0,1,0,0);          // start: RUN, no increment yet
    add(0,0,0, 1,1,1,0,0);
    add(0,0,0, 2,2,1,0,0);
    add(0,0,1, 3,2,1,0,1);          // single-cycle injection
    add(0,1,0, 4,4,1,0,1);          // realigned; start in RUN ignored
    add(0,0,0, 5,5,1,0,1);
    add(0,1,0, 6,6,1,0,1);
    for (int k = 7; k <= 9; k++) add(0,0,0, k,k,1,0,1);
    add(0,0,1, 10,11,0,1,2);        // inject on final increment sticks into DONE
    add(0,0,0, 10,11,0,1,2);
    add(0,0,1, 10,11,0,1,2);        // inject in DONE ignored
    add(0,1,0, 0,0,1,0,0);          // restart from DONE
    for (int k = 1; k <= 5; k++) add(0,0,0, k,k,1,0,0);
    add(1,0,1, 0,0,0,0,0);          // reset mid-run overrides inject
    add(0,0,0, 0,0,0,0,0);          // stays IDLE
    add(0,1,1, 0,0,1,0,0);          // inject on start edge ignored
    for (int k = 1; k <= 9; k++) add(0,0,0, k,k,1,0,0);
    add(0,0,0, 10,10,0,1,0);
    add(0,1,1, 0,0,1,0,0);          // restart from DONE, inject ignored
    add(0,0,0, 1,1,1,0,0);

    for (int i = 0; i < tbl.size(); i++) step0(tbl[i], i);
    rst0 = 1'b0; start0 = 1'b0; inj0 = 1'b0;

    // dut1 has been held in reset throughout
    chk("w.reset.a", int'(a1), 0);
    chk("w.reset.busy", int'(busy1), 0);
    chk("w.reset.done", int'(done1), 0);

    // Wrap run of 20 increments with inject held for two consecutive edges
    begin
      vec_t v;
      v.rst = 1'b0; v.start = 1'b1; v.inject = 1'b0;
      v.a = 4'd0; v.b = 4'd0; v.busy = 1'b1; v.done = 1'b0; v.cnt = 8'd0;
      step1(v, 0);
      for (int k = 1; k <= 20; k++) begin
        int av;
        logic ij;
        ij = (k == 7) || (k == 8);
        av = k % 16;
        v.start = 1'b0; v.inject = ij;
        v.a = av[3:0];
        v.b = av[3:0] ^ {3'b000, ij};
        v.busy = (k < 20);
        v.done = (k == 20);
        v.cnt = (k < 7) ? 8'd0 : ((k == 7) ? 8'd1 : 8'd2);
        step1(v, k);
      end
      for (int k = 21; k <= 22; k++) begin
        v.start = 1'b0; v.inject = 1'b1;
        v.a = 4'd4; v.b = 4'd4; v.busy = 1'b0; v.done = 1'b1; v.cnt = 8'd2;
        step1(v, k);
      end
    end

    chk("queues_drained", q0.size() + q1.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lockstep_stim_gen.md
Name: lockstep_stim_gen

Overview:
- Stimulus-side counterpart to the team's sampled-value equality checkers.
- Drives two WIDTH-bit counter streams, a_o and b_o, that advance in lockstep on every RUN cycle for a programmed number of cycles, then signals completion.
- Supports single-cycle mismatch injection on b_o so a downstream `$sampled(a) == $sampled(b)` property can be shown to fire.
- Sits in the regression bench between the test control logic and the checker under test.

Parameters:
- WIDTH, 4, bit width of both counter streams.
- NUM_CYCLES, 10, number of increments per run; legal range 1 to 65535.
- INJ_MASK, 1, XOR mask applied to b_o on an injected cycle; must be nonzero.
- LAG, 1, delay of b_o behind a_o in cycles; used only with STIM_GEN_LAG_EN; legal range 1 to 8.

Ports:
- clk  input  1  sole clock; all state updates on its posedge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  begins a run when sampled in IDLE or DONE.
- inject  input  1  corrupts b_o on this RUN cycle's update.
- a_o  output  WIDTH  reference counter stream.
- b_o  output  WIDTH  mirrored counter stream.
- busy  output  1  high while in RUN.
- done  output  1  high in DONE; sticky until the next start or rst.
- inj_cnt  output  8  number of injections this run; saturates at 255.

Behaviour:
- Reset: rst sampled high forces state=IDLE and a_o=0, b_o=0, busy=0, done=0, inj_cnt=0, internal cycle counter=0. rst overrides start and inject on the same edge.
- States: IDLE, RUN, DONE.
- IDLE/DONE, start=1 on an edge: next state RUN, busy=1, done=0, a_o=0, b_o=0, inj_cnt=0, cycle counter=0. No increment happens on this edge.
- RUN, each edge:
  - a_o <= a_o+1, modulo 2^WIDTH (silent wrap).
  - b_o <= (a_o+1) ^ (inject ? INJ_MASK : 0).
  - Cycle counter increments.
- RUN exit: on the edge that performs increment number NUM_CYCLES, next state is DONE, busy=0, done=1. a_o and b_o then hold their values.
- Injection:
  - Affects only the b_o value loaded on that edge.
  - b_o realigns with a_o on the next RUN edge unless inject is held high.
  - inject outside RUN is ignored.
  - inj_cnt increments once per RUN edge with inject=1.
- start in RUN is ignored; a run cannot be restarted mid-flight.
- start in DONE restarts a run immediately, with the same effect as from IDLE.
- inject and the final increment on the same edge: the injection applies and is counted; b_o stays corrupted in DONE, since no later RUN edge realigns it.
- Latency: start to first increment is 2 edges. start to done is NUM_CYCLES+1 edges.

Optional Feature:
- Macro: STIM_GEN_LAG_EN.
- With the macro defined:
  - b_o is the value of the b_o computation above, delayed LAG cycles through a shift register.
  - The delay stages reset to 0 on rst and on start.
  - done asserts LAG edges after the last increment, so the final b_o value has emerged.
  - busy stays high until then.
- Without the macro: LAG is ignored, no delay stages exist, and timing is exactly as in Behaviour.

Decomposition:
- Package lockstep_stim_pkg holds:
  - the state enum (IDLE, RUN, DONE);
  - the inj_cnt width constant (8);
  - the saturation limit (255).
- One sub-module, stim_delay_line: parameterised WIDTH x LAG register chain with synchronous clear, instantiated only under STIM_GEN_LAG_EN.

Test Plan:
- Basic run: WIDTH=4, NUM_CYCLES=10, start pulsed at edge 0 -> busy=1 from edge 0; a_o=b_o=1 after edge 1, 10 after edge 10; done=1, busy=0 after edge 10.
- Wrap: NUM_CYCLES=20 -> a_o passes 15 then 0; final a_o=b_o=4, done=1.
- Injection: INJ_MASK=1, inject high on the edge producing a_o=3 -> b_o=2 for one cycle; next edge a_o=b_o=4; final inj_cnt=1.
- Restart/ignore: start held high during RUN -> run still completes at a_o=10. start in DONE -> a_o=0, done=0, busy=1 on the next edge.
- Reset mid-run: rst high at a_o=5 with inject=1 -> next edge all outputs 0, state IDLE, inj_cnt=0.
- With STIM_GEN_LAG_EN, LAG=2 -> b_o equals a_o from 2 cycles earlier; done asserts 2 edges after a_o reaches 10.
